// File: rtl/arb_pkg.sv
// Shared types and constants for the LRU grant arbiter.
// Imported by the arbiter top level and its pick sub-module.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int POLICY_FIXED = 0;
    localparam int POLICY_LRU   = 1;

endpackage

// File: rtl/lru_grant_arbiter_priority_pick.sv
// Combinational pick: first entry in list order whose requester is active.
// The order is a flat vector, entry p at bits [p*IDW +: IDW].
module priority_pick
    import arb_pkg::*;
#(
    parameter int CANDIDATE = 4,
    parameter int IDW       = $clog2(CANDIDATE)
) (
    input  logic [CANDIDATE-1:0]     request_vec,
    input  logic [CANDIDATE*IDW-1:0] order,
    output logic                     pick_valid,
    output logic [IDW-1:0]           pick_number
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        pick_valid  = 1'b0;
        pick_number = '0;
        w_idx       = '0;
        for (int p = 0; p < CANDIDATE; p++) begin
            w_idx = order[p*IDW +: IDW];
            if (!pick_valid && request_vec[w_idx]) begin
                pick_valid  = 1'b1;
                pick_number = w_idx;
            end
        end
    end

endmodule

// File: rtl/lru_grant_arbiter.sv
// Packet-locked output-port arbiter with least-recently-granted rotation.
// All outputs are registered; the pick always sees the next-cycle order.
module lru_grant_arbiter
    import arb_pkg::*;
#(
    parameter int CANDIDATE = 4,
    parameter int POLICY    = 1,
    parameter int IDW       = $clog2(CANDIDATE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CANDIDATE-1:0]     request_vec,
    input  logic                     grant_ready,
    input  logic                     grant_last,
    output logic                     grant_valid,
    output logic [IDW-1:0]           grant_number,
    output logic [CANDIDATE-1:0]     grant_onehot,
    output logic [CANDIDATE*IDW-1:0] priority_array
);

    arb_state_t                 r_state;
    logic                       r_valid;
    logic [IDW-1:0]             r_num;
    logic [CANDIDATE-1:0]       r_oh;
    logic [CANDIDATE*IDW-1:0]   r_order;

    logic [CANDIDATE*IDW-1:0]   w_identity;
    logic [CANDIDATE*IDW-1:0]   w_lru;
    logic [CANDIDATE*IDW-1:0]   w_order_next;
    logic [IDW-1:0]             w_gpos;
    logic                       w_release;
    logic                       w_pick_valid;
    logic [IDW-1:0]             w_pick_num;
    logic [CANDIDATE-1:0]       w_pick_oh;

    always_comb begin
        w_identity = '0;
        for (int p = 0; p < CANDIDATE; p++) begin
            w_identity[p*IDW +: IDW] = IDW'(p);
        end
    end

    assign w_release = r_valid && grant_ready && grant_last;

    // Remove the granted entry, close the gap, append it at the tail.
    always_comb begin
        w_gpos = '0;
        for (int p = 0; p < CANDIDATE; p++) begin
            if (r_order[p*IDW +: IDW] == r_num) begin
                w_gpos = IDW'(p);
            end
        end
        w_lru = r_order;
        for (int q = 0; q < CANDIDATE - 1; q++) begin
            if (q >= int'(w_gpos)) begin
                w_lru[q*IDW +: IDW] = r_order[(q+1)*IDW +: IDW];
            end
        end
        w_lru[(CANDIDATE-1)*IDW +: IDW] = r_num;
    end

    assign w_order_next = (w_release && POLICY == POLICY_LRU)
                        ? w_lru : r_order;

    priority_pick #(
        .CANDIDATE (CANDIDATE),
        .IDW       (IDW)
    ) u_pick (
        .request_vec (request_vec),
        .order       (w_order_next),
        .pick_valid  (w_pick_valid),
        .pick_number (w_pick_num)
    );

    assign w_pick_oh = CANDIDATE'(1) << w_pick_num;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_num   <= '0;
            r_oh    <= '0;
            r_order <= w_identity;
        end else begin
            r_order <= w_order_next;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= BUSY;
                        r_valid <= 1'b1;
                        r_num   <= w_pick_num;
                        r_oh    <= w_pick_oh;
                    end
                end
                BUSY: begin
                    if (w_release && w_pick_valid) begin
                        r_num   <= w_pick_num;
                        r_oh    <= w_pick_oh;
                    end else if (w_release || !request_vec[r_num]) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_num   <= '0;
                        r_oh    <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_num   <= '0;
                    r_oh    <= '0;
                end
            endcase
        end
    end

    assign grant_valid    = r_valid;
    assign grant_number   = r_num;
    assign grant_onehot   = r_oh;
    assign priority_array = r_order;

endmodule

// File: tb/tb_lru_grant_arbiter.sv
// Directed bench for lru_grant_arbiter: LRU instance plus a fixed-order one.
// Order vectors are flat, entry p at bits [2p+1:2p].
module tb_lru_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] request_vec;
    logic       grant_ready;
    logic       grant_last;

    logic       l_valid;
    logic [1:0] l_num;
    logic [3:0] l_oh;
    logic [7:0] l_order;

    logic       f_valid;
    logic [1:0] f_num;
    logic [3:0] f_oh;
    logic [7:0] f_order;

    int checks;
    int errors;

    lru_grant_arbiter #(.CANDIDATE(4), .POLICY(1)) u_lru (
        .clk            (clk),
        .rst            (rst),
        .request_vec    (request_vec),
        .grant_ready    (grant_ready),
        .grant_last     (grant_last),
        .grant_valid    (l_valid),
        .grant_number   (l_num),
        .grant_onehot   (l_oh),
        .priority_array (l_order)
    );

    lru_grant_arbiter #(.CANDIDATE(4), .POLICY(0)) u_fix (
        .clk            (clk),
        .rst            (rst),
        .request_vec    (request_vec),
        .grant_ready    (grant_ready),
        .grant_last     (grant_last),
        .grant_valid    (f_valid),
        .grant_number   (f_num),
        .grant_onehot   (f_oh),
        .priority_array (f_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lru(input string tag, input logic v, input logic [1:0] n,
                       input logic [3:0] oh, input logic [7:0] ord);
        chk({tag, ".valid"}, 32'(l_valid), 32'(v));
        chk({tag, ".num"},   32'(l_num),   32'(n));
        chk({tag, ".oh"},    32'(l_oh),    32'(oh));
        chk({tag, ".order"}, 32'(l_order), 32'(ord));
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        request_vec = 4'b0000;
        grant_ready = 1'b0;
        grant_last  = 1'b0;
        tick();
        tick();
        lru("reset", 1'b0, 2'd0, 4'b0000, 8'he4);
        chk("fix_reset.order", 32'(f_order), 32'h00e4);
        #2 rst = 1'b0;

        // First grant, then release with nothing pending.
        request_vec = 4'b1010;
        tick();
        lru("first", 1'b1, 2'd1, 4'b0010, 8'he4);
        request_vec = 4'b0000;
        grant_ready = 1'b1;
        grant_last  = 1'b1;
        tick();
        lru("rel_idle", 1'b0, 2'd0, 4'b0000, 8'h78);

        // Back-to-back rotation from identity.
        do_reset();
        request_vec = 4'b1111;
        tick();
        lru("b2b0", 1'b1, 2'd0, 4'b0001, 8'he4);
        tick();
        lru("b2b1", 1'b1, 2'd1, 4'b0010, 8'h39);
        tick();
        lru("b2b2", 1'b1, 2'd2, 4'b0100, 8'h4e);
        tick();
        lru("b2b3", 1'b1, 2'd3, 4'b1000, 8'h93);
        tick();
        lru("b2b4", 1'b1, 2'd0, 4'b0001, 8'he4);

        // Multi-beat lock on 2 with a stall in the middle.
        do_reset();
        request_vec = 4'b0100;
        grant_last  = 1'b0;
        tick();
        lru("lock_g", 1'b1, 2'd2, 4'b0100, 8'he4);
        request_vec = 4'b0101;
        tick();
        lru("lock_b1", 1'b1, 2'd2, 4'b0100, 8'he4);
        tick();
        lru("lock_b2", 1'b1, 2'd2, 4'b0100, 8'he4);
        grant_ready = 1'b0;
        grant_last  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        lru("stall", 1'b1, 2'd2, 4'b0100, 8'he4);
        grant_ready = 1'b1;
        tick();
        lru("lock_rel", 1'b1, 2'd0, 4'b0001, 8'hb4);

        // Hand over to 3, then abort by dropping request 3.
        request_vec = 4'b1000;
        tick();
        lru("to3", 1'b1, 2'd3, 4'b1000, 8'h2d);
        request_vec = 4'b0000;
        grant_ready = 1'b0;
        grant_last  = 1'b0;
        tick();
        lru("abort", 1'b0, 2'd0, 4'b0000, 8'h2d);
        tick();
        lru("abort_idle", 1'b0, 2'd0, 4'b0000, 8'h2d);

        // Asynchronous reset in the middle of a packet.
        request_vec = 4'b0010;
        tick();
        lru("pre_rst", 1'b1, 2'd1, 4'b0010, 8'h2d);
        #2 rst = 1'b1;
        #1;
        lru("mid_rst", 1'b0, 2'd0, 4'b0000, 8'he4);
        rst = 1'b0;

        // Release coinciding with request drop.
        request_vec = 4'b0001;
        tick();
        lru("drop_g", 1'b1, 2'd0, 4'b0001, 8'he4);
        request_vec = 4'b0000;
        grant_ready = 1'b1;
        grant_last  = 1'b1;
        tick();
        lru("drop_rel", 1'b0, 2'd0, 4'b0000, 8'h39);

        // Fixed policy: always 0, order never moves.
        do_reset();
        request_vec = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fix.valid", 32'(f_valid), 32'd1);
            chk("fix.num",   32'(f_num),   32'd0);
            chk("fix.oh",    32'(f_oh),    32'h1);
            chk("fix.order", 32'(f_order), 32'he4);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
